// File: rtl/uart_ram_bank_router_if.sv
// Regmap-side access bus plus the shared block_ram bank bus of the UART RAM bank router.
// The router takes the slave modport; the regmap/bank side takes the master modport.
interface uart_ram_bank_router_if #(
   parameter int NUM_BANKS      = 4,
   parameter int NUM_ADDR_BYTES = 2,
   parameter int RAM_ADDR_BITS  = 13
);
   logic [6:0]                  slave_id;
   logic [NUM_ADDR_BYTES*8-1:0] address;
   logic                        write_enable;
   logic                        read_enable;
   logic                        send_slave_id;
   logic [7:0]                  wr_data;
   logic [NUM_BANKS-1:0]        bank_we;
   logic [NUM_BANKS-1:0]        bank_re;
   logic [RAM_ADDR_BITS-1:0]    bank_addr;
   logic [7:0]                  bank_wdata;
   logic [NUM_BANKS*8-1:0]      bank_rdata;
   logic [7:0]                  send_data;
   logic                        rd_valid;
   logic                        err_irq;

   modport slave (
      input  slave_id, address, write_enable, read_enable, send_slave_id, wr_data, bank_rdata,
      output bank_we, bank_re, bank_addr, bank_wdata, send_data, rd_valid, err_irq
   );

   modport master (
      output slave_id, address, write_enable, read_enable, send_slave_id, wr_data, bank_rdata,
      input  bank_we, bank_re, bank_addr, bank_wdata, send_data, rd_valid, err_irq
   );
endinterface

// File: rtl/uart_ram_bank_router.sv
// Routes UART regmap byte accesses to NUM_BANKS block_ram banks plus one status slave
// (write-protect, sticky errors, write count); read data is latency-aligned and held for TX.
module uart_ram_bank_router #(
   parameter int NUM_BANKS      = 4,
   parameter int BASE_ID        = 1,
   parameter int NUM_ADDR_BYTES = 2,
   parameter int RAM_ADDR_BITS  = 13,
   parameter int RAM_LATENCY    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   uart_ram_bank_router_if.slave bus
);
   localparam int LAST = RAM_LATENCY - 1;

   typedef enum logic [1:0] {K_ZERO, K_BANK, K_STAT} kind_t;

   int                   rel_id;
   logic                 bank_hit;
   logic                 stat_hit;
   logic                 in_range;
   logic                 stat_in_range;
   logic                 access;
   logic                 stat_wr;
   logic [NUM_BANKS-1:0] hit_vec;
   logic [NUM_BANKS-1:0] we_vec;
   logic [2:0]           err_set;
   kind_t                kind_in;

   logic [NUM_BANKS-1:0] wp_mask;
   logic [2:0]           err_flags;
   logic [15:0]          wr_count;
   logic [7:0]           rd_hold;
   logic                 rd_valid;

   logic [RAM_LATENCY-1:0] vld_p;
   kind_t                  kind_p [RAM_LATENCY];
   logic [2:0]             idx_p  [RAM_LATENCY];
   logic [1:0]             off_p  [RAM_LATENCY];

   logic [7:0] stat_rd;
   logic [7:0] out_byte;
   int         out_sel;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Decode stage: same-cycle strobes and error detection
   always_comb begin
      rel_id        = int'(bus.slave_id) - BASE_ID;
      bank_hit      = (rel_id >= 0) && (rel_id < NUM_BANKS);
      stat_hit      = (int'(bus.slave_id) == BASE_ID + NUM_BANKS);
      in_range      = (bus.address >> RAM_ADDR_BITS) == '0;
      stat_in_range = (bus.address >> 2) == '0;
      access        = bus.write_enable | bus.read_enable;
      stat_wr       = bus.write_enable & stat_hit & stat_in_range;
      for (int k = 0; k < NUM_BANKS; k++) begin
         hit_vec[k] = bank_hit && in_range && (rel_id == k);
      end
      we_vec     = {NUM_BANKS{bus.write_enable}} & hit_vec & ~wp_mask;
      err_set[0] = access & ~bank_hit & ~stat_hit;
      err_set[1] = access & ((bank_hit & ~in_range) | (stat_hit & ~stat_in_range));
      err_set[2] = bus.write_enable & (|(hit_vec & wp_mask));
      kind_in    = K_ZERO;
      if (bank_hit && in_range) begin
         kind_in = K_BANK;
      end else if (stat_hit && stat_in_range) begin
         kind_in = K_STAT;
      end
   end

   assign bus.bank_we    = we_vec;
   assign bus.bank_re    = {NUM_BANKS{bus.read_enable}} & hit_vec;
   assign bus.bank_addr  = bus.address[RAM_ADDR_BITS-1:0];
   assign bus.bank_wdata = bus.wr_data;

   // Read descriptor pipeline: travels alongside the RAM so every read sees the same latency
   always_ff @(posedge clk) begin
      kind_p[0] <= kind_in;
      idx_p[0]  <= 3'(rel_id);
      off_p[0]  <= bus.address[1:0];
      for (int s = 1; s < RAM_LATENCY; s++) begin
         kind_p[s] <= kind_p[s-1];
         idx_p[s]  <= idx_p[s-1];
         off_p[s]  <= off_p[s-1];
      end
   end

   // Output stage: status registers are sampled when the read completes, not when it was issued
   always_comb begin
      stat_rd = 8'h00;
      case (off_p[LAST])
         2'd0:    stat_rd[NUM_BANKS-1:0] = wp_mask;
         2'd1:    stat_rd[2:0] = err_flags;
         2'd2:    stat_rd = wr_count[7:0];
         default: stat_rd = wr_count[15:8];
      endcase
      out_sel  = int'(idx_p[LAST]);
      out_byte = 8'h00;
      case (kind_p[LAST])
         K_BANK:  out_byte = bus.bank_rdata[out_sel*8 +: 8];
         K_STAT:  out_byte = stat_rd;
         default: out_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p     <= '0;
         rd_valid  <= 1'b0;
         rd_hold   <= 8'h00;
         wp_mask   <= '0;
         err_flags <= 3'b000;
         wr_count  <= 16'h0000;
      end else begin
         vld_p[0] <= bus.read_enable;
         for (int s = 1; s < RAM_LATENCY; s++) begin
            vld_p[s] <= vld_p[s-1];
         end
         rd_valid <= vld_p[LAST];
         if (vld_p[LAST]) begin
            rd_hold <= out_byte;
         end
         if (stat_wr && bus.address[1:0] == 2'd0) begin
            wp_mask <= bus.wr_data[NUM_BANKS-1:0];
         end
         // A new error in the clearing cycle survives the clear
         err_flags <= ((stat_wr && bus.address[1:0] == 2'd1) ? 3'b000 : err_flags) | err_set;
         if (stat_wr && bus.address[1:0] == 2'd2) begin
            wr_count <= 16'h0000;
         end else if (|we_vec) begin
            wr_count <= sat_inc(wr_count);
         end
      end
   end

   assign bus.rd_valid  = rd_valid;
   assign bus.err_irq   = |err_flags;
   assign bus.send_data = bus.send_slave_id ? {bus.read_enable, bus.slave_id} : rd_hold;
endmodule

// File: tb/tb_uart_ram_bank_router.sv
// Directed bench for uart_ram_bank_router with a 2-cycle-latency RAM model behind the bank bus.
module tb_uart_ram_bank_router;
   localparam int NUM_BANKS      = 4;
   localparam int BASE_ID        = 1;
   localparam int NUM_ADDR_BYTES = 2;
   localparam int RAM_ADDR_BITS  = 13;
   localparam int RAM_LATENCY    = 2;
   localparam logic [6:0] STAT_ID = 7'(BASE_ID + NUM_BANKS);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_tests = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   uart_ram_bank_router_if #(.NUM_BANKS(NUM_BANKS), .NUM_ADDR_BYTES(NUM_ADDR_BYTES),
                             .RAM_ADDR_BITS(RAM_ADDR_BITS)) bi ();

   uart_ram_bank_router #(.NUM_BANKS(NUM_BANKS), .BASE_ID(BASE_ID), .NUM_ADDR_BYTES(NUM_ADDR_BYTES),
                          .RAM_ADDR_BITS(RAM_ADDR_BITS), .RAM_LATENCY(RAM_LATENCY)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bi)
   );

   // Read-first RAM model, two registered stages of read latency
   logic [7:0] mem   [NUM_BANKS][2**RAM_ADDR_BITS];
   logic [7:0] rd_s1 [NUM_BANKS];
   logic [7:0] rd_s2 [NUM_BANKS];

   initial begin
      for (int k = 0; k < NUM_BANKS; k++) begin
         rd_s1[k] = 8'h00;
         rd_s2[k] = 8'h00;
         for (int a = 0; a < 2**RAM_ADDR_BITS; a++) mem[k][a] = 8'h00;
      end
   end

   always @(posedge clk) begin
      for (int k = 0; k < NUM_BANKS; k++) begin
         if (bi.bank_we[k]) mem[k][bi.bank_addr] <= bi.bank_wdata;
         if (bi.bank_re[k]) rd_s1[k] <= mem[k][bi.bank_addr];
         rd_s2[k] <= rd_s1[k];
      end
   end

   assign bi.bank_rdata = {rd_s2[3], rd_s2[2], rd_s2[1], rd_s2[0]};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [6:0] sid, input logic [15:0] addr, input logic we,
                        input logic re, input logic [7:0] d);
      bi.slave_id     = sid;
      bi.address      = addr;
      bi.write_enable = we;
      bi.read_enable  = re;
      bi.wr_data      = d;
   endtask

   task automatic idle();
      bi.write_enable = 1'b0;
      bi.read_enable  = 1'b0;
   endtask

   task automatic do_write(input logic [6:0] sid, input logic [15:0] addr, input logic [7:0] d);
      drive(sid, addr, 1'b1, 1'b0, d);
      tick();
      idle();
   endtask

   // Issues one read (optionally with a write) and waits, bounded, for rd_valid.
   // lat counts clock edges from the strobe edge to the edge that raised rd_valid.
   task automatic do_read(input logic [6:0] sid, input logic [15:0] addr, input logic we,
                          input logic [7:0] wd, output logic [7:0] data, output int lat,
                          output logic [3:0] re_seen, output logic [3:0] we_seen);
      drive(sid, addr, we, 1'b1, wd);
      #1;
      re_seen = bi.bank_re;
      we_seen = bi.bank_we;
      @(posedge clk);
      #1;
      idle();
      lat = 0;
      while (!bi.rd_valid && lat < 10) begin
         tick();
         lat++;
      end
      data = bi.send_data;
   endtask

   task automatic test_reset();
      logic [7:0] d;
      int lat;
      logic [3:0] r, w;
      bi.send_slave_id = 1'b0;
      drive(7'd0, 16'h0000, 1'b0, 1'b0, 8'h00);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (bi.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rd_valid: got %b expected 0", bi.rd_valid); end
      n_tests++; if (bi.err_irq !== 1'b0) begin n_fail++; $display("FAIL rst_err_irq: got %b expected 0", bi.err_irq); end
      n_tests++; if (bi.send_data !== 8'h00) begin n_fail++; $display("FAIL rst_send_data: got %h expected 00", bi.send_data); end
      n_tests++; if (bi.bank_we !== 4'b0000) begin n_fail++; $display("FAIL rst_bank_we: got %b expected 0000", bi.bank_we); end
      rst_n = 1'b1;
      tick();
      do_read(STAT_ID, 16'h0000, 1'b0, 8'h00, d, lat, r, w);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_wp_mask: got %h expected 00", d); end
      do_read(STAT_ID, 16'h0002, 1'b0, 8'h00, d, lat, r, w);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_wr_count: got %h expected 00", d); end
   endtask

   task automatic test_write_read();
      logic [7:0] d;
      int lat;
      logic [3:0] r, w;
      drive(7'd2, 16'h0010, 1'b1, 1'b0, 8'hA5);
      #1;
      n_tests++; if (bi.bank_we !== 4'b0010) begin n_fail++; $display("FAIL wr_bank_we: got %b expected 0010", bi.bank_we); end
      n_tests++; if (bi.bank_addr !== 13'h0010) begin n_fail++; $display("FAIL wr_bank_addr: got %h expected 0010", bi.bank_addr); end
      n_tests++; if (bi.bank_wdata !== 8'hA5) begin n_fail++; $display("FAIL wr_bank_wdata: got %h expected a5", bi.bank_wdata); end
      n_tests++; if (bi.bank_re !== 4'b0000) begin n_fail++; $display("FAIL wr_bank_re: got %b expected 0000", bi.bank_re); end
      @(posedge clk);
      #1;
      idle();
      do_read(7'd2, 16'h0010, 1'b0, 8'h00, d, lat, r, w);
      n_tests++; if (r !== 4'b0010) begin n_fail++; $display("FAIL rd_bank_re: got %b expected 0010", r); end
      n_tests++; if (lat !== RAM_LATENCY) begin n_fail++; $display("FAIL rd_latency: got %0d expected %0d", lat, RAM_LATENCY); end
      n_tests++; if (d !== 8'hA5) begin n_fail++; $display("FAIL rd_data: got %h expected a5", d); end
      tick();
      n_tests++; if (bi.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_pulse: got %b expected 0", bi.rd_valid); end
      n_tests++; if (bi.send_data !== 8'hA5) begin n_fail++; $display("FAIL rd_hold_stable: got %h expected a5", bi.send_data); end
      bi.slave_id = 7'h2A;
      bi.send_slave_id = 1'b1;
      #1;
      n_tests++; if (bi.send_data !== 8'h2A) begin n_fail++; $display("FAIL send_slave_echo: got %h expected 2a", bi.send_data); end
      bi.send_slave_id = 1'b0;
      tick();
      do_write(7'd3, 16'h0030, 8'h01);
      do_read(7'd3, 16'h0030, 1'b1, 8'h5A, d, lat, r, w);
      n_tests++; if (w !== 4'b0100 || r !== 4'b0100) begin n_fail++; $display("FAIL rw_strobes: got we=%b re=%b expected 0100/0100", w, r); end
      n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL rw_old_data: got %h expected 01", d); end
      do_read(7'd3, 16'h0030, 1'b0, 8'h00, d, lat, r, w);
      n_tests++; if (d !== 8'h5A) begin n_fail++; $display("FAIL rw_new_data: got %h expected 5a", d); end
   endtask

   task automatic test_write_protect();
      logic [7:0] d;
      int lat;
      logic [3:0] r, w;
      do_write(7'd1, 16'h0020, 8'h11);
      do_write(STAT_ID, 16'h0000, 8'h01);
      do_read(STAT_ID, 16'h0000, 1'b0, 8'h00, d, lat, r, w);
      n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL wp_readback: got %h expected 01", d); end
      drive(7'd1, 16'h0020, 1'b1, 1'b0, 8'h77);
      #1;
      n_tests++; if (bi.bank_we !== 4'b0000) begin n_fail++; $display("FAIL wp_bank_we: got %b expected 0000", bi.bank_we); end
      @(posedge clk);
      #1;
      idle();
      n_tests++; if (bi.err_irq !== 1'b1) begin n_fail++; $display("FAIL wp_err_irq: got %b expected 1", bi.err_irq); end
      do_read(STAT_ID, 16'h0001, 1'b0, 8'h00, d, lat, r, w);
      n_tests++; if (d !== 8'h04) begin n_fail++; $display("FAIL wp_err_flags: got %h expected 04", d); end
      do_read(7'd1, 16'h0020, 1'b0, 8'h00, d, lat, r, w);
      n_tests++; if (d !== 8'h11) begin n_fail++; $display("FAIL wp_data_kept: got %h expected 11", d); end
      do_write(STAT_ID, 16'h0001, 8'h00);
      n_tests++; if (bi.err_irq !== 1'b0) begin n_fail++; $display("FAIL wp_irq_clear: got %b expected 0", bi.err_irq); end
      do_read(STAT_ID, 16'h0001, 1'b0, 8'h00, d, lat, r, w);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL wp_flags_clear: got %h expected 00", d); end
      do_write(STAT_ID, 16'h0000, 8'h00);
   endtask

   task automatic test_errors();
      logic [7:0] d;
      int lat;
      logic [3:0] r, w;
      do_read(7'd9, 16'h0000, 1'b0, 8'h00, d, lat, r, w);
      n_tests++; if (d !== 8'h00 || lat !== RAM_LATENCY) begin n_fail++; $display("FAIL unmapped_rd: got %h lat %0d expected 00 lat %0d", d, lat, RAM_LATENCY); end
      do_read(7'd1, 16'h2000, 1'b0, 8'h00, d, lat, r, w);
      n_tests++; if (r !== 4'b0000) begin n_fail++; $display("FAIL oor_bank_re: got %b expected 0000", r); end
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL oor_rd: got %h expected 00", d); end
      do_read(STAT_ID, 16'h0001, 1'b0, 8'h00, d, lat, r, w);
      n_tests++; if (d !== 8'h03) begin n_fail++; $display("FAIL err_flags_03: got %h expected 03", d); end
      n_tests++; if (bi.err_irq !== 1'b1) begin n_fail++; $display("FAIL err_irq_set: got %b expected 1", bi.err_irq); end
      do_write(STAT_ID, 16'h0001, 8'h00);
      n_tests++; if (bi.err_irq !== 1'b0) begin n_fail++; $display("FAIL err_irq_clr: got %b expected 0", bi.err_irq); end
   endtask

   task automatic test_back_to_back();
      logic       vseen [8];
      logic [7:0] dseen [8];
      logic       expv;
      for (int k = 0; k < NUM_BANKS; k++) do_write(7'(BASE_ID + k), 16'h0100, 8'((k + 1) * 17));
      drive(7'(BASE_ID), 16'h0100, 1'b0, 1'b1, 8'h00);
      for (int c = 0; c < 8; c++) begin
         tick();
         if (c < 3) bi.slave_id = 7'(BASE_ID + c + 1);
         else idle();
         vseen[c] = bi.rd_valid;
         dseen[c] = bi.send_data;
      end
      for (int c = 0; c < 8; c++) begin
         expv = (c >= RAM_LATENCY) && (c < RAM_LATENCY + 4);
         n_tests++; if (vseen[c] !== expv) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected %b", c, vseen[c], expv); end
         if (expv) begin
            n_tests++; if (dseen[c] !== 8'((c - RAM_LATENCY + 1) * 17)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", c, dseen[c], 8'((c - RAM_LATENCY + 1) * 17)); end
         end
      end
   endtask

   task automatic test_wr_count();
      logic [7:0] d;
      int lat;
      logic [3:0] r, w;
      do_write(STAT_ID, 16'h0002, 8'h00);
      drive(7'd1, 16'h0000, 1'b1, 1'b0, 8'h3C);
      repeat (300) tick();
      idle();
      do_read(STAT_ID, 16'h0002, 1'b0, 8'h00, d, lat, r, w);
      n_tests++; if (d !== 8'h2C) begin n_fail++; $display("FAIL cnt300_lo: got %h expected 2c", d); end
      do_read(STAT_ID, 16'h0003, 1'b0, 8'h00, d, lat, r, w);
      n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL cnt300_hi: got %h expected 01", d); end
      do_write(STAT_ID, 16'h0000, 8'h01);
      do_write(7'd1, 16'h0000, 8'h00);
      do_write(STAT_ID, 16'h0000, 8'h00);
      do_write(STAT_ID, 16'h0001, 8'h00);
      do_read(STAT_ID, 16'h0002, 1'b0, 8'h00, d, lat, r, w);
      n_tests++; if (d !== 8'h2C) begin n_fail++; $display("FAIL cnt_blocked: got %h expected 2c", d); end
      drive(7'd2, 16'h0000, 1'b1, 1'b0, 8'h3C);
      repeat (65535 - 300) tick();
      idle();
      do_read(STAT_ID, 16'h0003, 1'b0, 8'h00, d, lat, r, w);
      n_tests++; if (d !== 8'hFF) begin n_fail++; $display("FAIL cnt_max_hi: got %h expected ff", d); end
      do_write(7'd2, 16'h0000, 8'h00);
      do_read(STAT_ID, 16'h0002, 1'b0, 8'h00, d, lat, r, w);
      n_tests++; if (d !== 8'hFF) begin n_fail++; $display("FAIL cnt_sat_lo: got %h expected ff", d); end
      do_read(STAT_ID, 16'h0003, 1'b0, 8'h00, d, lat, r, w);
      n_tests++; if (d !== 8'hFF) begin n_fail++; $display("FAIL cnt_sat_hi: got %h expected ff", d); end
      do_write(STAT_ID, 16'h0002, 8'h00);
      do_read(STAT_ID, 16'h0003, 1'b0, 8'h00, d, lat, r, w);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL cnt_clear: got %h expected 00", d); end
   endtask

   task automatic test_reset_mid_read();
      logic [7:0] d;
      int lat;
      logic [3:0] r, w;
      logic seen;
      do_read(7'd2, 16'h0010, 1'b0, 8'h00, d, lat, r, w);
      n_tests++; if (d !== 8'hA5) begin n_fail++; $display("FAIL mid_pre_data: got %h expected a5", d); end
      do_write(7'd1, 16'h0000, 8'h00);
      drive(7'd2, 16'h0010, 1'b0, 1'b1, 8'h00);
      tick();
      idle();
      rst_n = 1'b0;
      #2;
      n_tests++; if (bi.send_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_hold: got %h expected 00", bi.send_data); end
      tick();
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         tick();
         if (bi.rd_valid) seen = 1'b1;
      end
      n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_no_valid: got %b expected 0", seen); end
      n_tests++; if (bi.send_data !== 8'h00) begin n_fail++; $display("FAIL mid_send_data: got %h expected 00", bi.send_data); end
      do_read(STAT_ID, 16'h0002, 1'b0, 8'h00, d, lat, r, w);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL mid_cnt_reset: got %h expected 00", d); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_write_protect();
      test_errors();
      test_back_to_back();
      test_wr_count();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
